// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: Decode feedback, CP0 redirects, IM bus and F/D pipeline register.
// Latency: wires only; timing belongs to the fetch_stage that drives the master side.
// Backpressure: stall travels in this bundle and freezes PC plus F/D when asserted.
//
// master: the fetch stage. Drives i_inst_addr and the D_* register outputs.
// slave : the environment (Decode/CP0/IM). Drives the controls, targets and i_inst_rdata.
interface fetch_stage_if;
  logic        stall;
  logic        req;
  logic        D_eret;
  logic [31:0] epc;
  logic [2:0]  npc_sel;
  logic        D_IsBranch;
  logic [15:0] br_imm16;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_IsDelay;
  logic [4:0]  D_ExcCode;

  modport master (
    input  stall, req, D_eret, epc, npc_sel, D_IsBranch,
           br_imm16, j_index, jr_target, i_inst_rdata,
    output i_inst_addr, D_PC, D_instr, D_IsDelay, D_ExcCode
  );

  modport slave (
    output stall, req, D_eret, epc, npc_sel, D_IsBranch,
           br_imm16, j_index, jr_target, i_inst_rdata,
    input  i_inst_addr, D_PC, D_instr, D_IsDelay, D_ExcCode
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, addresses IM and holds the F/D register feeding Decode.
// Latency: 1 cycle from i_inst_addr to the F/D register; all outputs registered.
// Backpressure: stall holds PC and F/D; req (CP0) overrides stall, stall overrides eret.
//
// Ports: clk, reset (async, active-high), bus (fetch_stage_if.master):
//   in : stall, req, D_eret, epc, npc_sel, D_IsBranch, br_imm16, j_index, jr_target, i_inst_rdata
//   out: i_inst_addr (= F PC), D_PC, D_instr, D_IsDelay, D_ExcCode
// Build option: define FETCH_ADDR_CHECK_EN to raise AdEL (code 4) on misaligned or
//   out-of-range fetch addresses; otherwise the fetch exception code is always 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
`ifdef FETCH_ADDR_CHECK_EN
  ,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
`endif
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        d_is_delay_q, d_is_delay_d;
  logic [4:0]  d_exc_code_q, d_exc_code_d;

  logic        f_adel;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  // Fetch address check on the PC currently presented to IM. A redirect to a
  // bad address is accepted into the PC; the fault surfaces when it is fetched.
`ifdef FETCH_ADDR_CHECK_EN
  assign f_adel = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_LO) || (f_pc_q > IMEM_HI);
`else
  assign f_adel = 1'b0;
`endif

  assign br_offset = {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};

  // Branch/jump targets are relative to the instruction sitting in D.
  always_comb begin
    next_pc = f_pc_q + 32'd4;
    case (bus.npc_sel)
      3'd1:    next_pc = d_pc_q + 32'd4 + br_offset;
      3'd2:    next_pc = {d_pc_q[31:28], bus.j_index, 2'b00};
      3'd3:    next_pc = bus.jr_target;
      default: next_pc = f_pc_q + 32'd4;
    endcase
  end

  // Priority: req > stall > eret > normal fetch.
  always_comb begin
    f_pc_d       = f_pc_q;
    d_pc_d       = d_pc_q;
    d_instr_d    = d_instr_q;
    d_is_delay_d = d_is_delay_q;
    d_exc_code_d = d_exc_code_q;
    if (bus.req) begin
      f_pc_d       = HANDLER_PC;
      d_pc_d       = HANDLER_PC;
      d_instr_d    = 32'd0;
      d_is_delay_d = 1'b0;
      d_exc_code_d = EXC_NONE;
    end else if (bus.stall) begin
      // hold everything; npc_sel is ignored while stalled
    end else if (bus.D_eret) begin
      // eret has no delay slot: the word fetched this cycle becomes a bubble
      f_pc_d       = bus.epc;
      d_pc_d       = bus.epc;
      d_instr_d    = 32'd0;
      d_is_delay_d = 1'b0;
      d_exc_code_d = EXC_NONE;
    end else begin
      f_pc_d       = next_pc;
      d_pc_d       = f_pc_q;
      d_instr_d    = f_adel ? 32'd0 : bus.i_inst_rdata;
      d_is_delay_d = bus.D_IsBranch;
      d_exc_code_d = f_adel ? EXC_ADEL : EXC_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q       <= RESET_PC;
      d_pc_q       <= RESET_PC;
      d_instr_q    <= 32'd0;
      d_is_delay_q <= 1'b0;
      d_exc_code_q <= EXC_NONE;
    end else begin
      f_pc_q       <= f_pc_d;
      d_pc_q       <= d_pc_d;
      d_instr_q    <= d_instr_d;
      d_is_delay_q <= d_is_delay_d;
      d_exc_code_q <= d_exc_code_d;
    end
  end

  assign bus.i_inst_addr = f_pc_q;
  assign bus.D_PC        = d_pc_q;
  assign bus.D_instr     = d_instr_q;
  assign bus.D_IsDelay   = d_is_delay_q;
  assign bus.D_ExcCode   = d_exc_code_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed PC / F-D register values per edge.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall, req and eret exercised alone and in combination.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miscmp;

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  fetch_stage_if fif ();

  fetch_stage dut (
    .clk   (clk),
    .reset (rst),
    .bus   (fif)
  );

  // Instruction memory image: a recognisable word per address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign fif.i_inst_rdata = imem_word(fif.i_inst_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] f, input logic [31:0] dpc,
                             input logic [31:0] dinstr, input logic dly, input logic [4:0] exc);
    chk({tag, ".f_pc"},    fif.i_inst_addr, f);
    chk({tag, ".d_pc"},    fif.D_PC, dpc);
    chk({tag, ".d_instr"}, fif.D_instr, dinstr);
    chk({tag, ".d_dly"},   {31'd0, fif.D_IsDelay}, {31'd0, dly});
    chk({tag, ".d_exc"},   {27'd0, fif.D_ExcCode}, {27'd0, exc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected F/D contents when the fetched word at a is a bad address (check enabled).
  function automatic logic [31:0] bad_instr(input logic [31:0] a);
    return CHK_ON ? 32'd0 : imem_word(a);
  endfunction

  function automatic logic [4:0] bad_exc();
    return CHK_ON ? 5'd4 : 5'd0;
  endfunction

  initial begin
    n_vec          = 0;
    n_miscmp       = 0;
    rst            = 1'b1;
    fif.stall      = 1'b0;
    fif.req        = 1'b0;
    fif.D_eret     = 1'b0;
    fif.epc        = 32'd0;
    fif.npc_sel    = 3'd0;
    fif.D_IsBranch = 1'b0;
    fif.br_imm16   = 16'd0;
    fif.j_index    = 26'd0;
    fif.jr_target  = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check_state("rst", 32'h3000, 32'h3000, 32'd0, 1'b0, 5'd0);
    rst = 1'b0;

    // Sequential fetch, D_PC one cycle behind.
    step(); check_state("seq1", 32'h3004, 32'h3000, imem_word(32'h3000), 1'b0, 5'd0);
    step(); check_state("seq2", 32'h3008, 32'h3004, imem_word(32'h3004), 1'b0, 5'd0);
    step(); check_state("seq3", 32'h300c, 32'h3008, imem_word(32'h3008), 1'b0, 5'd0);
    step(); check_state("seq4", 32'h3010, 32'h300c, imem_word(32'h300c), 1'b0, 5'd0);
    step(); check_state("seq5", 32'h3014, 32'h3010, imem_word(32'h3010), 1'b0, 5'd0);

    // Backward branch from D_PC=0x3010: 0x3014 - 8 = 0x300c; delay slot tagged.
    fif.npc_sel = 3'd1; fif.br_imm16 = 16'hfffe; fif.D_IsBranch = 1'b1;
    step(); check_state("br", 32'h300c, 32'h3014, imem_word(32'h3014), 1'b1, 5'd0);

    // Stall with jr pending: nothing moves, redirect only after release.
    fif.D_IsBranch = 1'b0; fif.stall = 1'b1; fif.npc_sel = 3'd3; fif.jr_target = 32'h3040;
    step(); check_state("stall1", 32'h300c, 32'h3014, imem_word(32'h3014), 1'b1, 5'd0);
    step(); check_state("stall2", 32'h300c, 32'h3014, imem_word(32'h3014), 1'b1, 5'd0);
    fif.stall = 1'b0;
    step(); check_state("jr", 32'h3040, 32'h300c, imem_word(32'h300c), 1'b0, 5'd0);

    // j: {D_PC[31:28], index, 00} with index 0x1410 -> 0x5040.
    fif.npc_sel = 3'd2; fif.j_index = 26'h0001410;
    step(); check_state("j", 32'h5040, 32'h3040, imem_word(32'h3040), 1'b0, 5'd0);

    // eret: bubble with PC=epc, then epc's word follows.
    fif.npc_sel = 3'd0; fif.D_eret = 1'b1; fif.epc = 32'h3020;
    step(); check_state("eret", 32'h3020, 32'h3020, 32'd0, 1'b0, 5'd0);
    fif.D_eret = 1'b0;
    step(); check_state("eret+1", 32'h3024, 32'h3020, imem_word(32'h3020), 1'b0, 5'd0);

    // stall beats eret.
    fif.stall = 1'b1; fif.D_eret = 1'b1; fif.epc = 32'h3100;
    step(); check_state("stall_eret", 32'h3024, 32'h3020, imem_word(32'h3020), 1'b0, 5'd0);

    // req beats eret.
    fif.stall = 1'b0; fif.req = 1'b1;
    step(); check_state("req_eret", 32'h4180, 32'h4180, 32'd0, 1'b0, 5'd0);
    fif.req = 1'b0; fif.D_eret = 1'b0;
    step(); check_state("handler", 32'h4184, 32'h4180, imem_word(32'h4180), 1'b0, 5'd0);

    // req beats stall.
    fif.stall = 1'b1; fif.req = 1'b1;
    step(); check_state("req_stall", 32'h4180, 32'h4180, 32'd0, 1'b0, 5'd0);
    fif.stall = 1'b0; fif.req = 1'b0;

    // Misaligned jr target accepted, AdEL on the following fetch.
    fif.npc_sel = 3'd3; fif.jr_target = 32'h3002;
    step(); check_state("jr_mis", 32'h3002, 32'h4180, imem_word(32'h4180), 1'b0, 5'd0);
    fif.npc_sel = 3'd0;
    step(); check_state("adel_mis", 32'h3006, 32'h3002, bad_instr(32'h3002), 1'b0, bad_exc());

    // Upper bound: 0x6ffc legal, 0x7000 not.
    fif.npc_sel = 3'd3; fif.jr_target = 32'h6ffc;
    step(); check_state("adel_mis2", 32'h6ffc, 32'h3006, bad_instr(32'h3006), 1'b0, bad_exc());
    fif.npc_sel = 3'd0;
    step(); check_state("hi_ok", 32'h7000, 32'h6ffc, imem_word(32'h6ffc), 1'b0, 5'd0);

    // Lower bound: 0x2ffc illegal, 0x3000 legal.
    fif.npc_sel = 3'd3; fif.jr_target = 32'h2ffc;
    step(); check_state("hi_bad", 32'h2ffc, 32'h7000, bad_instr(32'h7000), 1'b0, bad_exc());
    fif.npc_sel = 3'd0;
    step(); check_state("hi_bad2", 32'h3000, 32'h2ffc, bad_instr(32'h2ffc), 1'b0, bad_exc());
    step(); check_state("lo_ok", 32'h3004, 32'h3000, imem_word(32'h3000), 1'b0, 5'd0);

    // Async reset mid-stall, between edges.
    fif.stall = 1'b1;
    rst = 1'b1;
    #2;
    check_state("arst", 32'h3000, 32'h3000, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0; fif.stall = 1'b0;
    step(); check_state("post_rst", 32'h3004, 32'h3000, imem_word(32'h3000), 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
